wb_write_arbiter: RTL and testbench

Write-port driver for the processor register file. Merges single-cycle writebacks from the main pipeline with completions from the multi-cycle load/multiply unit into one registered write port (RegWrite/writereg/writedata). It buffers multi-cycle results in a small FIFO and keeps a pending-register scoreboard so that hazard logic can stall readers of registers that are still in flight.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/wb_write_arbiter_if.sv | 41 ++++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_write_arbiter.sv | 111 +++++++++++
 tb/tb_wb_write_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared register-file write-port types for the processor pipeline.
// A write request is one destination register plus its result.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of writeback sources, issue tracking and the merged register-file write port.
// The slave modport is the arbiter; the master modport is everything around it.
interface wb_write_arbiter_if
  import pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_wreg;
  logic [DATA_W-1:0] pipe_wdata;
  logic              ext_valid;
  logic              ext_ready;
  logic [ADDR_W-1:0] ext_wreg;
  logic [DATA_W-1:0] ext_wdata;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_wreg;
  logic [NREG-1:0]   busy_mask;
  logic              RegWrite;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] writedata;
  logic [CNT_W-1:0]  fifo_count;
  logic              wb_err;

  modport master (
    output pipe_we, pipe_wreg, pipe_wdata,
    output ext_valid, ext_wreg, ext_wdata,
    output issue_valid, issue_wreg,
    input  ext_ready, busy_mask, RegWrite, writereg, writedata, fifo_count, wb_err
  );

  modport slave (
    input  pipe_we, pipe_wreg, pipe_wdata,
    input  ext_valid, ext_wreg, ext_wdata,
    input  issue_valid, issue_wreg,
    output ext_ready, busy_mask, RegWrite, writereg, writedata, fifo_count, wb_err
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write requests; the head is readable in the same cycle
// it is popped so a buffered result can be emitted without an extra stage.
module wb_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          wr_data,
  input  logic             pop,
  output wb_req_t          rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port: pipeline writebacks take priority, buffered multi-cycle
// results fill idle slots, and a scoreboard tracks registers with results in flight.
module wb_write_arbiter
  import pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_req_t           push_req;
  wb_req_t           head;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              ext_ready;
  logic              ext_acc;
  logic              pipe_sel;

  logic              regwrite_reg;
  logic [ADDR_W-1:0] writereg_reg;
  logic [DATA_W-1:0] writedata_reg;
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic              wb_err_reg;
  logic              wb_err_next;
  logic              err_issue;
  logic              err_ext;
  logic              err_pipe;

  // Readiness looks only at occupancy; a same-cycle pop never opens a slot.
  assign ext_ready = !rst && !fifo_full;
  assign ext_acc   = bus.ext_valid && ext_ready;
  assign fifo_push = ext_acc && (bus.ext_wreg != '0);
  assign push_req  = '{wreg: bus.ext_wreg, wdata: bus.ext_wdata};

  // A pipeline write to r0 is dropped, so it leaves the slot free for the FIFO.
  assign pipe_sel  = bus.pipe_we && (bus.pipe_wreg != '0);
  assign fifo_pop  = !pipe_sel && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (push_req),
    .pop     (fifo_pop),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign set_vec[gi] = 1'b0;
      end else begin : g_rn
        assign set_vec[gi] = bus.issue_valid && (bus.issue_wreg == ADDR_W'(gi));
      end
      assign clr_vec[gi]   = fifo_pop && (head.wreg == ADDR_W'(gi));
      // A new issue outranks the retirement of the older op to the same register.
      assign busy_next[gi] = set_vec[gi] || (busy_reg[gi] && !clr_vec[gi]);
    end
  endgenerate

  assign err_issue   = bus.issue_valid && busy_reg[bus.issue_wreg] && !clr_vec[bus.issue_wreg];
  assign err_ext     = fifo_push && !busy_reg[bus.ext_wreg];
  assign err_pipe    = bus.pipe_we && busy_reg[bus.pipe_wreg];
  assign wb_err_next = wb_err_reg || err_issue || err_ext || err_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_reg  <= 1'b0;
      writereg_reg  <= '0;
      writedata_reg <= '0;
      busy_reg      <= '0;
      wb_err_reg    <= 1'b0;
    end else begin
      regwrite_reg <= pipe_sel || fifo_pop;
      if (pipe_sel) begin
        writereg_reg  <= bus.pipe_wreg;
        writedata_reg <= bus.pipe_wdata;
      end else if (fifo_pop) begin
        writereg_reg  <= head.wreg;
        writedata_reg <= head.wdata;
      end
      busy_reg   <= busy_next;
      wb_err_reg <= wb_err_next;
    end
  end

  assign bus.ext_ready  = ext_ready;
  assign bus.busy_mask  = busy_reg;
  assign bus.RegWrite   = regwrite_reg;
  assign bus.writereg   = writereg_reg;
  assign bus.writedata  = writedata_reg;
  assign bus.fifo_count = count;
  assign bus.wb_err     = wb_err_reg;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a vector table with hand-derived status expectations,
// a queue scoreboard for every write-port cycle, and a short randomised merge run.
module tb_wb_write_arbiter;

  logic clk;
  logic rst;

  wb_write_arbiter_if bus ();

  wb_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wr_t;

  typedef struct {
    logic        r;
    logic        pw;
    logic [4:0]  preg;
    logic [31:0] pdat;
    logic        ev;
    logic [4:0]  ereg;
    logic [31:0] edat;
    logic        iv;
    logic [4:0]  ireg;
    logic [31:0] busy;
    logic        err;
    logic        rdy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t        tbl[$];
  wr_t         model_q[$];
  logic [4:0]  last_reg;
  logic [31:0] last_data;
  logic        last_acc;
  int          checks;
  int          passes;

  function automatic vec_t v(logic r, logic pw, int preg, int pdat, logic ev, int ereg,
                             int edat, logic iv, int ireg, int busy, logic err, logic rdy,
                             int cnt);
    vec_t t;
    t.r = r; t.pw = pw; t.preg = 5'(preg); t.pdat = 32'(pdat);
    t.ev = ev; t.ereg = 5'(ereg); t.edat = 32'(edat);
    t.iv = iv; t.ireg = 5'(ireg);
    t.busy = 32'(busy); t.err = err; t.rdy = rdy; t.cnt = 3'(cnt);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock: predict the write port from the scoreboard, then compare after the edge.
  task automatic tick();
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    wr_t         e;
    last_acc = bus.ext_valid && !rst && (model_q.size() < 4);
    exp_we   = 1'b0;
    exp_reg  = last_reg;
    exp_data = last_data;
    if (rst) begin
      model_q.delete();
      exp_reg  = '0;
      exp_data = '0;
    end else if (bus.pipe_we && bus.pipe_wreg != 5'd0) begin
      exp_we   = 1'b1;
      exp_reg  = bus.pipe_wreg;
      exp_data = bus.pipe_wdata;
    end else if (model_q.size() > 0) begin
      e        = model_q.pop_front();
      exp_we   = 1'b1;
      exp_reg  = e.wreg;
      exp_data = e.wdata;
    end
    if (last_acc && bus.ext_wreg != 5'd0) model_q.push_back({bus.ext_wreg, bus.ext_wdata});
    @(posedge clk);
    #1;
    chk("write", {bus.RegWrite, bus.writereg, bus.writedata}, {exp_we, exp_reg, exp_data});
    $display("cycle: RegWrite=%0b writereg=%0d writedata=%08h busy=%08h cnt=%0d err=%0b",
             bus.RegWrite, bus.writereg, bus.writedata, bus.busy_mask, bus.fifo_count,
             bus.wb_err);
    last_reg  = exp_reg;
    last_data = exp_data;
  endtask

  task automatic drive_idle();
    bus.pipe_we = 0; bus.pipe_wreg = '0; bus.pipe_wdata = '0;
    bus.ext_valid = 0; bus.ext_wreg = '0; bus.ext_wdata = '0;
    bus.issue_valid = 0; bus.issue_wreg = '0;
  endtask

  initial begin
    int pushed;
    checks = 0; passes = 0; last_reg = '0; last_data = '0; last_acc = 0;
    rst = 1'b1;
    drive_idle();

    //          r pw preg pdat    ev ereg edat     iv ireg busy       err rdy cnt
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,1,5,'hAA,    0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,1,0,'h55,    0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,7,  'h80,     0,1,0));
    tbl.push_back(v(0,0,0,0,       1,7,'h1234,    0,0,  'h80,     0,1,1));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    for (int r = 1; r <= 4; r++)
      tbl.push_back(v(0,0,0,0,     0,0,0,         1,r,  (1 << (r + 1)) - 2, 0,1,0));
    for (int r = 1; r <= 4; r++)
      tbl.push_back(v(0,1,10,'h100+r-1, 1,r,'h11*r, 0,0, 'h1E,     0,(r < 4),r));
    tbl.push_back(v(0,1,10,'h104,  1,5,'h55,      0,0,  'h1E,     0,0,4));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h1C,     0,1,3));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h18,     0,1,2));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h10,     0,1,1));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,6,  'h40,     0,1,0));
    tbl.push_back(v(0,0,0,0,       1,6,'h66,      0,0,  'h40,     0,1,1));
    tbl.push_back(v(0,1,0,'h77,    0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,8,  'h100,    0,1,0));
    tbl.push_back(v(0,0,0,0,       1,8,'h88,      1,11, 'h900,    0,1,1));
    tbl.push_back(v(0,0,0,0,       1,11,'hBB,     0,0,  'h800,    0,1,1));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       1,0,'hDEAD,    0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,9,  'h200,    0,1,0));
    tbl.push_back(v(0,0,0,0,       1,9,'h99,      0,0,  'h200,    0,1,1));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,9,  'h200,    0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,9,  'h200,    1,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h200,    1,1,0));
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    for (int r = 1; r <= 3; r++)
      tbl.push_back(v(0,0,0,0,     0,0,0,         1,r,  (1 << (r + 1)) - 2, 0,1,0));
    for (int r = 1; r <= 3; r++)
      tbl.push_back(v(0,1,12,'hC0+r-1, 1,r,'hA0+r, 0,0, 'h0E,     0,1,r));
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       1,13,'h13,     0,0,  'h0,      1,1,1));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      1,1,0));
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         1,14, 'h4000,   0,1,0));
    tbl.push_back(v(0,1,14,'hE,    0,0,0,         0,0,  'h4000,   1,1,0));
    tbl.push_back(v(1,0,0,0,       0,0,0,         0,0,  'h0,      0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,         0,0,  'h0,      0,1,0));

    foreach (tbl[i]) begin
      rst             = tbl[i].r;
      bus.pipe_we     = tbl[i].pw;
      bus.pipe_wreg   = tbl[i].preg;
      bus.pipe_wdata  = tbl[i].pdat;
      bus.ext_valid   = tbl[i].ev;
      bus.ext_wreg    = tbl[i].ereg;
      bus.ext_wdata   = tbl[i].edat;
      bus.issue_valid = tbl[i].iv;
      bus.issue_wreg  = tbl[i].ireg;
      tick();
      chk($sformatf("busy_mask row %0d", i), bus.busy_mask, tbl[i].busy);
      chk($sformatf("wb_err row %0d", i), bus.wb_err, tbl[i].err);
      chk($sformatf("ext_ready row %0d", i), bus.ext_ready, tbl[i].rdy);
      chk($sformatf("fifo_count row %0d", i), bus.fifo_count, tbl[i].cnt);
    end

    // Randomised merge: r16..r23 are issued, then their results race pipeline writes.
    drive_idle();
    for (int r = 16; r < 24; r++) begin
      bus.issue_valid = 1; bus.issue_wreg = 5'(r);
      tick();
    end
    drive_idle();
    chk("busy after issues", bus.busy_mask, 32'h00FF_0000);
    pushed = 0;
    for (int c = 0; c < 80; c++) begin
      bus.pipe_we    = ($urandom_range(0, 2) != 0);
      bus.pipe_wreg  = (bus.pipe_we && $urandom_range(0, 8) != 0) ? 5'($urandom_range(24, 31)) : 5'd0;
      bus.pipe_wdata = $urandom;
      bus.ext_valid  = (pushed < 8) && ($urandom_range(0, 1) != 0);
      bus.ext_wreg   = 5'(16 + (pushed % 8));
      bus.ext_wdata  = $urandom;
      tick();
      if (last_acc) pushed++;
      chk($sformatf("fifo_count rand %0d", c), bus.fifo_count, 3'(model_q.size()));
    end
    drive_idle();
    for (int c = 0; c < 20 && (model_q.size() > 0 || pushed < 8); c++) begin
      if (pushed < 8) begin
        bus.ext_valid = 1; bus.ext_wreg = 5'(16 + pushed); bus.ext_wdata = $urandom;
      end else begin
        bus.ext_valid = 0;
      end
      tick();
      if (last_acc) pushed++;
    end
    drive_idle();
    tick();
    chk("drain pushed", 64'(pushed), 64'd8);
    chk("drain busy", bus.busy_mask, 32'h0);
    chk("drain count", bus.fifo_count, 3'd0);
    chk("drain err", bus.wb_err, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
